coin_acceptor: RTL
==================

# coin_acceptor

Front-end stage for `fsm_vending` that conditions the raw coin-sensor and return-button lines. Each line is synchronized and debounced, and each press becomes a single event. Events are buffered in a small in-order FIFO, then released to `fsm_vending` as clean one-cycle `coin_5` / `coin_10` / `coin_25` / `coin_return` strobes. Released strobes are spaced at least one idle cycle apart. Release is gated by a downstream enable so coins inserted while the vending FSM is busy are not lost.

## Interface
- `DEBOUNCE_CYCLES`, default 4 — consecutive stable synchronized cycles required before a debounced level changes; legal range ≥ 2.
- `FIFO_DEPTH`, default 4 — event buffer entries; power of two, ≥ 2.
- `clk`  in  1 — single clock; all state changes on the rising edge.
- `rst`  in  1 — synchronous, active-high reset.
- `sense_5`, `sense_10`, `sense_25`  in  1 each — raw coin-sensor levels, asynchronous, may bounce.
- `return_btn`  in  1 — raw coin-return button level, asynchronous, may bounce.
- `accept_en`  in  1 — downstream may take a strobe this cycle.
- `coin_5`, `coin_10`, `coin_25`, `coin_return`  out  1 each — registered one-cycle strobes to `fsm_vending`; at most one is high in any cycle.
- `reject`  out  1 — registered one-cycle pulse when a detected event is discarded.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1) — number of buffered events.

## Operation
- **Synchronizer:** each of the four raw inputs passes through a 2-flop synchronizer (`s1`, then `s2`).
- **Debouncer:** one per input, with a debounced level `deb` and a counter `cnt`.
  - If `s2` == `deb`, `cnt` clears.
  - Otherwise `cnt` increments. When `cnt` == `DEBOUNCE_CYCLES-1` and `s2` still differs, `deb` takes `s2` and `cnt` clears.
  - A rising update of `deb` (0→1) is an event. Falling updates generate nothing.
- **Event codes:** 0 = 5c, 1 = 10c, 2 = 25c, 3 = return.
- **Push arbitration**, at most one push per cycle:
  - Two or more coin events in the same cycle: all are discarded and `reject` pulses.
  - Exactly one coin event: pushed.
  - A return event in the same cycle as a coin push sets `ret_pending`. The pending return is pushed on the first later cycle with no coin push.
  - A return event with no coin event: pushed directly.
  - Push attempted while the FIFO is full: the event is discarded and `reject` pulses. A pending return stays pending until space frees.
- **FIFO:** circular buffer with read/write pointers; a pointer at `FIFO_DEPTH-1` wraps to 0. A push and a pop in the same cycle leave the count unchanged. A push when full never overwrites.
- **Release FSM:**
  - States:
    - `IDLE`: may pop.
    - `GAP`: one mandatory low cycle after any strobe.
  - Transitions:
    - `IDLE` → `GAP` on a pop; the pop occurs when the FIFO is non-empty and `accept_en` = 1.
    - `GAP` → `IDLE` unconditionally.
  - The pop registers the strobe selected by the popped code.
- **Order:** events reach `fsm_vending` strictly in detection order; a return never overtakes earlier coins.
- **Reset:** applies regardless of state.
  - All strobes, `reject` and `fifo_count` read 0 in the cycle after the reset edge.
  - Synchronizers, `deb`, `cnt`, pointers and `ret_pending` all clear, and the FSM goes to `IDLE`.
  - Buffered coins are dropped by design.
  - An input already held high at reset release produces an event once it has been debounced.

## Timing
- **Latency:** a raw input is high before edge k and held. Then:
  - `s2` = 1 after edge k+1.
  - `deb` rises and the event is pushed at edge k+1+`DEBOUNCE_CYCLES`.
  - The strobe register sets at edge k+2+`DEBOUNCE_CYCLES`, if `accept_en` = 1 and nothing is ahead of it in the FIFO.
  - With the default, the strobe is high in the cycle following edge k+6.
- **Glitch filtering:** a raw pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- **Strobe spacing:** minimum strobe-to-strobe spacing is 2 cycles; with `accept_en` held high, a full FIFO drains one event every 2 cycles.
- **`accept_en` sampling:** `accept_en` is sampled only in `IDLE`. Deasserting it during `GAP` has no effect on the strobe already issued.
- **`fifo_count`:** registered; it reflects pushes and pops at the same edge they occur.

## Test plan
- **Single coin:** reset 2 cycles, then `sense_10` high for 12 cycles with `accept_en` = 1 → exactly one `coin_10` pulse, high 1 cycle, starting 6 cycles after the first sampling edge. `fifo_count` goes 0 → 1 → 0. `reject` stays 0.
- **Bounce:** `sense_25` toggles with a 3-cycle high, 1-cycle low pattern, then holds high for 10 cycles → exactly one `coin_25` pulse. A lone 3-cycle `sense_5` glitch → no strobe.
- **Simultaneous coins:** `sense_5` and `sense_25` rise together and are held → one `reject` pulse, no coin strobe, `fifo_count` stays 0.
- **Overflow:** `accept_en` = 0; insert 5c, 10c, 25c, 5c, 10c one at a time →
  - `fifo_count` = 4 and the fifth event gives one `reject` pulse.
  - Raising `accept_en` → `coin_5`, `coin_10`, `coin_25`, `coin_5` on alternate cycles, then `fifo_count` = 0.
- **Ordering and simultaneous return:** `sense_5` and `return_btn` rise in the same cycle → `coin_5` strobe, then `coin_return` exactly 2 cycles later.
- **Reset mid-operation:** 3 events buffered with `accept_en` = 0; assert `rst` for 1 cycle, then raise `accept_en` → `fifo_count` = 0 the cycle after reset and no strobes follow.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: conditions raw coin-sensor and return-button lines for the
// vending FSM. Each line is synchronized, debounced and edge-detected; events
// are queued in order and released as one-cycle strobes with a gap cycle.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sense_5,
  input  logic                              sense_10,
  input  logic                              sense_25,
  input  logic                              return_btn,
  input  logic                              accept_en,
  output logic                              coin_5,
  output logic                              coin_10,
  output logic                              coin_25,
  output logic                              coin_return,
  output logic                              reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [CNTW-1:0] FCNT_MAX = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] FCNT_ONE = CNTW'(1);

  // Event codes as stored in the queue
  localparam logic [1:0] CODE_5   = 2'd0;
  localparam logic [1:0] CODE_10  = 2'd1;
  localparam logic [1:0] CODE_25  = 2'd2;
  localparam logic [1:0] CODE_RET = 2'd3;

  // Release FSM states
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  logic [3:0]      raw_s;
  logic [3:0]      s1_q, s2_q;
  logic [3:0]      deb_q, deb_d;
  logic [CW-1:0]   cnt_q [4];
  logic [CW-1:0]   cnt_d [4];
  logic [3:0]      rise_s;

  logic            multi_s, single_s, full_s;
  logic [1:0]      coin_code_s;
  logic            push_s;
  logic [1:0]      push_code_s;
  logic            ret_pend_q, ret_pend_d;
  logic            reject_q, reject_d;

  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            pop_s;
  logic [1:0]      pop_code_s;

  logic [0:0]      state_q, state_d;
  logic [3:0]      strobe_q, strobe_d;

  assign raw_s = {return_btn, sense_25, sense_10, sense_5};

  // Two-flop synchronizer for all four raw lines
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= raw_s;
      s2_q <= s1_q;
    end
  end

  // Debounce each synchronized line; a rising update of the level is an event
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]  = deb_q[i];
      cnt_d[i]  = cnt_q[i];
      rise_s[i] = 1'b0;
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i]  = s2_q[i];
        cnt_d[i]  = {CW{1'b0}};
        rise_s[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debouncer level and stability counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign multi_s  = (rise_s[0] & rise_s[1]) | (rise_s[0] & rise_s[2]) |
                    (rise_s[1] & rise_s[2]);
  assign single_s = (|rise_s[2:0]) & ~multi_s;
  assign full_s   = (count_q == FCNT_MAX);

  // Encode the single detected coin
  always_comb begin
    if (rise_s[0]) begin
      coin_code_s = CODE_5;
    end else if (rise_s[1]) begin
      coin_code_s = CODE_10;
    end else begin
      coin_code_s = CODE_25;
    end
  end

  // Push arbitration: coins win; a concurrent return waits so it stays behind
  always_comb begin
    push_s      = 1'b0;
    push_code_s = CODE_5;
    reject_d    = 1'b0;
    ret_pend_d  = ret_pend_q;
    if (single_s) begin
      if (full_s) begin
        reject_d = 1'b1;
      end else begin
        push_s      = 1'b1;
        push_code_s = coin_code_s;
      end
      if (rise_s[3]) begin
        ret_pend_d = 1'b1;
      end else begin
        ret_pend_d = ret_pend_q;
      end
    end else begin
      if (multi_s) begin
        reject_d = 1'b1;
      end else begin
        reject_d = 1'b0;
      end
      if (ret_pend_q || rise_s[3]) begin
        if (!full_s) begin
          push_s      = 1'b1;
          push_code_s = CODE_RET;
          ret_pend_d  = 1'b0;
        end else if (ret_pend_q) begin
          // an already pending return simply waits for space
          ret_pend_d = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
      end else begin
        ret_pend_d = ret_pend_q;
      end
    end
  end

  assign pop_s      = (state_q == IDLE) && (count_q != {CNTW{1'b0}}) && accept_en;
  assign pop_code_s = mem_q[rptr_q];

  // Pointer wrap and occupancy bookkeeping
  always_comb begin
    if (push_s) begin
      wptr_d = (wptr_q == PTR_LAST) ? {PW{1'b0}} : (wptr_q + PTR_ONE);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == PTR_LAST) ? {PW{1'b0}} : (rptr_q + PTR_ONE);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + FCNT_ONE;
      2'b01:   count_d = count_q - FCNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Event storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= push_code_s;
    end
  end

  // FIFO control, pending-return flag and reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      count_q    <= {CNTW{1'b0}};
      ret_pend_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ret_pend_q <= ret_pend_d;
      reject_q   <= reject_d;
    end
  end

  // Release FSM next state and strobe selection from the popped code
  always_comb begin
    case (state_q)
      IDLE:    state_d = pop_s ? GAP : IDLE;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop_s) begin
      case (pop_code_s)
        CODE_5:   strobe_d = 4'b0001;
        CODE_10:  strobe_d = 4'b0010;
        CODE_25:  strobe_d = 4'b0100;
        CODE_RET: strobe_d = 4'b1000;
        default:  strobe_d = 4'b0000;
      endcase
    end else begin
      strobe_d = 4'b0000;
    end
  end

  // Release FSM state and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      strobe_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
    end
  end

  assign coin_5      = strobe_q[0];
  assign coin_10     = strobe_q[1];
  assign coin_25     = strobe_q[2];
  assign coin_return = strobe_q[3];
  assign reject      = reject_q;
  assign fifo_count  = count_q;

endmodule
